// File: rtl/relu_backprop_pkg.sv
// Shared definitions for the relu backward-pass block: lane width and the
// per-lane relu sign test / gradient gate used by the top level.
package relu_backprop_pkg;

    localparam int LANE_W = 8;

    // A lane survives relu only when it is strictly positive as a signed byte.
    function automatic logic lane_active(input logic signed [LANE_W-1:0] lane);
        return ~lane[LANE_W-1] & (|lane[LANE_W-2:0]);
    endfunction

    function automatic logic [LANE_W-1:0] lane_gate(input logic keep,
                                                    input logic signed [LANE_W-1:0] lane);
        return keep ? lane : '0;
    endfunction

endpackage

// File: rtl/relu_backprop_if.sv
// Forward-vector, gradient and gated-output handshakes of relu_backprop.
interface relu_backprop_if
    import relu_backprop_pkg::*;
#(
    parameter int SIZE = 4
);
    logic                   fwd_valid;
    logic [LANE_W*SIZE-1:0] fwd_in;
    logic                   fwd_ready;
    logic                   grad_valid;
    logic [LANE_W*SIZE-1:0] grad_in;
    logic                   grad_ready;
    logic                   out_valid;
    logic [LANE_W*SIZE-1:0] out_data;
    logic                   out_ready;

    modport master (
        output fwd_valid, fwd_in, grad_valid, grad_in, out_ready,
        input  fwd_ready, grad_ready, out_valid, out_data
    );

    modport slave (
        input  fwd_valid, fwd_in, grad_valid, grad_in, out_ready,
        output fwd_ready, grad_ready, out_valid, out_data
    );
endinterface

// File: rtl/relu_backprop_mask_fifo.sv
// W-bit x DEPTH synchronous FIFO holding relu sign masks; clear has priority
// over push and pop, and the count is derived from the accepted operations.
module relu_mask_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [W-1:0]     wdata_i,
    input  logic             pop_i,
    output logic [W-1:0]     rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o & ~clear_i;
    assign pop_ok  = pop_i & ~empty_o & ~clear_i;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (clear_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + PTR_W'(1);
            if (pop_ok)  rd_d = rd_q + PTR_W'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/relu_backprop.sv
// Backward pass of relu: stores a sign mask per forward vector and zeroes the
// gradient lanes whose forward input was not strictly positive.
module relu_backprop
    import relu_backprop_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    relu_backprop_if.slave   bus,
    output logic [CNT_W-1:0] mask_count_o
);
    localparam int VEC_W = LANE_W * SIZE;

    logic [SIZE-1:0]  fwd_mask, pop_mask;
    logic [VEC_W-1:0] gated;
    logic             fifo_full, fifo_empty, push, pop;
    logic [VEC_W-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;

    always_comb begin
        fwd_mask = '0;
        gated    = '0;
        for (int i = 0; i < SIZE; i++) begin
            fwd_mask[i] = lane_active(bus.fwd_in[i*LANE_W +: LANE_W]);
            gated[i*LANE_W +: LANE_W] = lane_gate(pop_mask[i], bus.grad_in[i*LANE_W +: LANE_W]);
        end
    end

    assign bus.fwd_ready = ~fifo_full;
    // A clear discards this cycle's pop, so no gradient is taken alongside it.
    assign bus.grad_ready = ~fifo_empty & (~out_valid_q | bus.out_ready) & ~clear_i;
    assign push = bus.fwd_valid & bus.fwd_ready;
    assign pop  = bus.grad_valid & bus.grad_ready;

    relu_mask_fifo #(
        .W     (SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock_i),
        .rst_ni  (reset_i),
        .clear_i (clear_i),
        .push_i  (push),
        .wdata_i (fwd_mask),
        .pop_i   (pop),
        .rdata_o (pop_mask),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (mask_count_o)
    );

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (pop) begin
            out_d       = gated;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q;

endmodule

// File: tb/tb_relu_backprop.sv
// Bench for relu_backprop: directed vector table, hand-written corner sequences
// and randomized traffic, all scored against a queue-based reference model.
module tb_relu_backprop;
    import relu_backprop_pkg::*;

    localparam int SIZE  = 4;
    localparam int DEPTH = 8;
    localparam int VEC_W = 32;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             clear = 1'b0;
    logic [CNT_W-1:0] mask_count;

    relu_backprop_if #(.SIZE(SIZE)) ifc();

    relu_backprop #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .clear_i      (clear),
        .bus          (ifc),
        .mask_count_o (mask_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: stored masks, pending output register.
    bit [SIZE-1:0]  mq[$];
    bit             m_ov;
    bit [VEC_W-1:0] m_out;

    typedef struct {
        bit [VEC_W-1:0] fwd;
        bit [VEC_W-1:0] grad;
        bit [VEC_W-1:0] exp_out;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit [SIZE-1:0] ref_mask(input bit [VEC_W-1:0] v);
        byte b;
        ref_mask = '0;
        for (int i = 0; i < SIZE; i++) begin
            b = v[i*8 +: 8];
            ref_mask[i] = (b > 0);
        end
    endfunction

    function automatic bit [VEC_W-1:0] ref_gate(input bit [SIZE-1:0] m, input bit [VEC_W-1:0] g);
        ref_gate = '0;
        for (int i = 0; i < SIZE; i++)
            ref_gate[i*8 +: 8] = m[i] ? g[i*8 +: 8] : 8'h00;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ov  = 1'b0;
        m_out = '0;
    endtask

    // One clock cycle with the currently driven inputs; entered and left at posedge+1.
    task automatic cycle();
        bit efr, egr, fa, ga;
        bit [SIZE-1:0]  m;
        bit [VEC_W-1:0] fin, gin;
        #1;
        efr = (mq.size() != DEPTH);
        egr = (mq.size() != 0) && (!m_ov || ifc.out_ready) && !clear;
        chk("fwd_ready", 64'(ifc.fwd_ready), 64'(efr));
        chk("grad_ready", 64'(ifc.grad_ready), 64'(egr));
        fa  = ifc.fwd_valid && efr;
        ga  = ifc.grad_valid && egr;
        fin = ifc.fwd_in;
        gin = ifc.grad_in;
        if (clear) begin
            mq.delete();
        end else begin
            if (ga) begin
                m     = mq.pop_front();
                m_out = ref_gate(m, gin);
            end
            if (fa) mq.push_back(ref_mask(fin));
        end
        if (ga) m_ov = 1'b1;
        else if (ifc.out_ready) m_ov = 1'b0;
        @(posedge clock);
        #1;
        chk("out_valid", 64'(ifc.out_valid), 64'(m_ov));
        chk("out", 64'(ifc.out_data), 64'(m_out));
        chk("mask_count", 64'(mask_count), 64'(mq.size()));
    endtask

    initial begin
        ifc.fwd_valid  = 1'b0;
        ifc.fwd_in     = '0;
        ifc.grad_valid = 1'b0;
        ifc.grad_in    = '0;
        ifc.out_ready  = 1'b1;
        model_reset();

        #2;
        chk("rst_out_valid", 64'(ifc.out_valid), 64'(0));
        chk("rst_out", 64'(ifc.out_data), 64'(0));
        chk("rst_count", 64'(mask_count), 64'(0));
        chk("rst_fwd_ready", 64'(ifc.fwd_ready), 64'(1));
        chk("rst_grad_ready", 64'(ifc.grad_ready), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Directed vectors: push one mask, gate one gradient, drain.
        tbl[0] = '{32'hFF804020, 32'h11223344, 32'h00003344};
        tbl[1] = '{32'hF0210100, 32'h7F7F7F7F, 32'h007F7F00};
        tbl[2] = '{32'h7F7F7F7F, 32'h80FF0102, 32'h80FF0102};
        tbl[3] = '{32'h00010080, 32'hFFFFFFFF, 32'h00FF0000};
        foreach (tbl[k]) begin
            ifc.fwd_valid = 1'b1;
            ifc.fwd_in    = tbl[k].fwd;
            cycle();
            ifc.fwd_valid = 1'b0;
            chk("tbl_count", 64'(mask_count), 64'(1));
            ifc.grad_valid = 1'b1;
            ifc.grad_in    = tbl[k].grad;
            cycle();
            ifc.grad_valid = 1'b0;
            chk("tbl_out_valid", 64'(ifc.out_valid), 64'(1));
            chk("tbl_out", 64'(ifc.out_data), 64'(tbl[k].exp_out));
            cycle();
        end

        // Fill to DEPTH, then push against a full FIFO while popping.
        ifc.fwd_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ifc.fwd_in = $urandom;
            cycle();
        end
        chk("full_count", 64'(mask_count), 64'(DEPTH));
        chk("full_fwd_ready", 64'(ifc.fwd_ready), 64'(0));
        ifc.fwd_in     = $urandom;
        ifc.grad_valid = 1'b1;
        ifc.grad_in    = $urandom;
        cycle();
        chk("after_pop_count", 64'(mask_count), 64'(DEPTH - 1));
        chk("after_pop_fwd_ready", 64'(ifc.fwd_ready), 64'(1));
        cycle();
        chk("push_pop_count", 64'(mask_count), 64'(DEPTH - 1));
        ifc.fwd_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ifc.grad_in = $urandom;
            cycle();
        end
        ifc.grad_valid = 1'b0;
        cycle();

        // Empty FIFO: gradient and push in the same cycle, no bypass.
        ifc.fwd_valid  = 1'b1;
        ifc.fwd_in     = 32'h01FF7F80;
        ifc.grad_valid = 1'b1;
        ifc.grad_in    = 32'hAABBCCDD;
        cycle();
        ifc.fwd_valid = 1'b0;
        cycle();
        ifc.grad_valid = 1'b0;
        chk("nobypass_out", 64'(ifc.out_data), 64'(32'hAA00CC00));
        cycle();

        // Downstream stall with gradients pending.
        ifc.fwd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifc.fwd_in = $urandom;
            cycle();
        end
        ifc.fwd_valid  = 1'b0;
        ifc.out_ready  = 1'b0;
        ifc.grad_valid = 1'b1;
        ifc.grad_in    = $urandom;
        cycle();
        ifc.grad_in = $urandom;
        for (int i = 0; i < 3; i++) cycle();
        chk("stall_count", 64'(mask_count), 64'(2));
        ifc.out_ready = 1'b1;
        cycle();
        ifc.grad_in = $urandom;
        cycle();
        ifc.grad_valid = 1'b0;
        cycle();

        // Synchronous clear with push and pop requested.
        ifc.fwd_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ifc.fwd_in = $urandom;
            cycle();
        end
        clear          = 1'b1;
        ifc.grad_valid = 1'b1;
        cycle();
        clear          = 1'b0;
        ifc.fwd_valid  = 1'b0;
        ifc.grad_valid = 1'b0;
        chk("clear_count", 64'(mask_count), 64'(0));

        // Asynchronous reset mid-stream with count=5 and an output pending.
        ifc.fwd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ifc.fwd_in = $urandom;
            cycle();
        end
        ifc.fwd_valid  = 1'b0;
        ifc.out_ready  = 1'b0;
        ifc.grad_valid = 1'b1;
        ifc.grad_in    = 32'h7F7F7F7F;
        cycle();
        ifc.grad_valid = 1'b0;
        chk("pre_rst_count", 64'(mask_count), 64'(5));
        chk("pre_rst_out_valid", 64'(ifc.out_valid), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(ifc.out_valid), 64'(0));
        chk("async_rst_out", 64'(ifc.out_data), 64'(0));
        chk("async_rst_count", 64'(mask_count), 64'(0));
        model_reset();
        #3;
        reset = 1'b1;
        ifc.out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_count", 64'(mask_count), 64'(0));
        chk("post_rst_fwd_ready", 64'(ifc.fwd_ready), 64'(1));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            ifc.fwd_valid  = 1'($urandom_range(0, 1));
            ifc.fwd_in     = $urandom;
            ifc.grad_valid = 1'($urandom_range(0, 1));
            ifc.grad_in    = $urandom;
            ifc.out_ready  = ($urandom_range(0, 3) != 0);
            clear          = ($urandom_range(0, 39) == 0);
            cycle();
        end
        clear          = 1'b0;
        ifc.fwd_valid  = 1'b0;
        ifc.out_ready  = 1'b1;
        ifc.grad_valid = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            ifc.grad_in = $urandom;
            cycle();
        end
        ifc.grad_valid = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
